// File: rtl/scramble_dl_pkg.sv
// Shared types for the ROM download bridge:
// FSM state encoding, FIFO entry layout, SDRAM word-address width.
package scramble_dl_pkg;

  localparam int SD_WADDR_W   = 22;
  localparam int ENTRY_ADDR_W = 25;

  typedef logic [0:0] dl_state_t;

  localparam dl_state_t ST_IDLE = 1'b0;
  localparam dl_state_t ST_REQ  = 1'b1;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } dl_entry_t;

  function automatic logic [1:0] byte_lanes(input logic a0);
    return {a0, ~a0};
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO of download entries with full/empty/count.
// A pop frees the slot a same-cycle push needs, so push-when-full-and-pop is accepted.
module dl_fifo
  import scramble_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  dl_entry_t                wdata,
  input  logic                     pop,
  output dl_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dl_entry_t       mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  // storage array, written on accepted pushes only
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wp] <= wdata;
  end

  // pointers wrap modulo DEPTH by natural overflow of AW bits
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_dl_bridge.sv
// ROM download to SDRAM bridge: byte strobes are queued in a FIFO
// and replayed as single-byte SDRAM writes with a req/ack handshake.
module rom_dl_bridge
  import scramble_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DL_ADDR_W  = 25
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  dl_download,
  input  logic                  dl_wr,
  input  logic [DL_ADDR_W-1:0]  dl_addr,
  input  logic [7:0]            dl_data,
  output logic                  sd_req,
  input  logic                  sd_ack,
  output logic [SD_WADDR_W-1:0] sd_addr,
  output logic [1:0]            sd_ds,
  output logic [15:0]           sd_din,
  output logic                  sd_we,
  output logic                  busy,
  output logic                  rom_loaded,
  output logic                  overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            wr_q;
  logic            dl_q;
  logic            push_q;
  logic            pend_end;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            dl_rise;
  logic            dl_fall;
  logic            unused_hi;
  dl_state_t       state;
  dl_entry_t       wr_ent;
  dl_entry_t       head;

  assign dl_rise   = dl_download & ~dl_q;
  assign dl_fall   = ~dl_download & dl_q;
  assign pop       = (state == ST_REQ) & sd_ack;
  assign busy      = (count != '0) | (state == ST_REQ);
  assign wr_ent    = '{addr: ENTRY_ADDR_W'(dl_addr), data: dl_data};
  assign unused_hi = ^head.addr[ENTRY_ADDR_W-1:SD_WADDR_W+1];

  // registered edge detect; the push fires one cycle after the dl_wr rise
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q   <= 1'b0;
      dl_q   <= 1'b0;
      push_q <= 1'b0;
    end else begin
      wr_q   <= dl_wr;
      dl_q   <= dl_download;
      push_q <= dl_wr & ~wr_q & dl_download;
    end
  end

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push_q),
    .wdata   (wr_ent),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // sticky drop flag: push into a full FIFO that is not popping this cycle
  always_ff @(posedge clk_sys) begin
    if (reset) overflow <= 1'b0;
    else if (push_q & full & ~pop) overflow <= 1'b1;
  end

  // request FSM: launch from the FIFO head, hold until ack, then pop
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= ST_IDLE;
      sd_req  <= 1'b0;
      sd_we   <= 1'b0;
      sd_addr <= '0;
      sd_ds   <= '0;
      sd_din  <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (!empty) begin
            sd_addr <= head.addr[SD_WADDR_W:1];
            sd_ds   <= byte_lanes(head.addr[0]);
            sd_din  <= {head.data, head.data};
            sd_req  <= 1'b1;
            sd_we   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        (state == ST_REQ): begin
          if (sd_ack) begin
            sd_req <= 1'b0;
            sd_we  <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // download-complete tracking: end seen, then nothing queued or in flight
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_end   <= 1'b0;
      rom_loaded <= 1'b0;
    end else if (dl_rise) begin
      pend_end   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      if (dl_fall) pend_end <= 1'b1;
      if (pend_end & empty & ~push_q & (state == ST_IDLE))
        rom_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge with hand-computed expectations.
// A monitor records every SDRAM request launch for later checking.
module tb_rom_dl_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_download;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        sd_req;
  logic        sd_ack;
  logic [21:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din;
  logic        sd_we;
  logic        busy;
  logic        rom_loaded;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic        req_q = 1'b0;
  logic [21:0] cap_addr [$];
  logic [1:0]  cap_ds   [$];
  logic [15:0] cap_din  [$];

  always #5 clk_sys = ~clk_sys;

  rom_dl_bridge #(
    .FIFO_DEPTH (4),
    .DL_ADDR_W  (25)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dl_download (dl_download),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .sd_req      (sd_req),
    .sd_ack      (sd_ack),
    .sd_addr     (sd_addr),
    .sd_ds       (sd_ds),
    .sd_din      (sd_din),
    .sd_we       (sd_we),
    .busy        (busy),
    .rom_loaded  (rom_loaded),
    .overflow    (overflow)
  );

  // record each request launch
  always @(posedge clk_sys) begin
    req_q <= sd_req;
    if (sd_req && !req_q) begin
      cap_addr.push_back(sd_addr);
      cap_ds.push_back(sd_ds);
      cap_din.push_back(sd_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clr_cap();
    cap_addr.delete();
    cap_ds.delete();
    cap_din.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    dl_wr  = 1'b0;
    sd_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr = 1'b0;
    tick();
  endtask

  task automatic ack_now();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n;
    n = 0;
    while (!sd_req && n < budget) begin
      tick();
      n++;
    end
    if (!sd_req) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic run_ack(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      sd_ack = sd_req && !sd_ack;
      tick();
    end
    sd_ack = 1'b0;
  endtask

  initial begin
    dl_download = 1'b0;
    dl_addr     = '0;
    dl_data     = '0;
    do_reset();

    // reset state
    chk("rst_req",  {31'd0, sd_req},     32'd0);
    chk("rst_we",   {31'd0, sd_we},      32'd0);
    chk("rst_busy", {31'd0, busy},       32'd0);
    chk("rst_rl",   {31'd0, rom_loaded}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow},   32'd0);
    chk("rst_bus",  {sd_addr, sd_ds, sd_din[7:0]}, 32'd0);
    chk("rst_din",  {16'd0, sd_din},     32'd0);

    // single byte, addr 3 data A5
    dl_download = 1'b1;
    tick();
    clr_cap();
    push_byte(25'h0003, 8'hA5);
    chk("s_lat0",  {31'd0, sd_req}, 32'd0);
    chk("s_busy0", {31'd0, busy},   32'd1);
    tick();
    chk("s_lat1",  {31'd0, sd_req}, 32'd1);
    chk("s_addr",  {10'd0, sd_addr}, 32'h1);
    chk("s_ds",    {30'd0, sd_ds},   32'h2);
    chk("s_din",   {16'd0, sd_din},  32'hA5A5);
    chk("s_we",    {31'd0, sd_we},   32'd1);
    tick();
    chk("s_hold",  {31'd0, sd_req},  32'd1);
    chk("s_holdA", {10'd0, sd_addr}, 32'h1);
    ack_now();
    chk("s_drop",  {31'd0, sd_req},  32'd0);
    chk("s_wedrp", {31'd0, sd_we},   32'd0);
    chk("s_idle",  {31'd0, busy},    32'd0);

    // dl_wr held high 5 cycles
    clr_cap();
    dl_addr = 25'h0010;
    dl_data = 8'h3C;
    dl_wr   = 1'b1;
    repeat (5) tick();
    dl_wr = 1'b0;
    run_ack(15);
    chk("h_nreq", cap_addr.size(), 32'd1);
    if (cap_addr.size() >= 1) begin
      chk("h_addr", {10'd0, cap_addr[0]}, 32'h8);
      chk("h_ds",   {30'd0, cap_ds[0]},   32'h1);
      chk("h_din",  {16'd0, cap_din[0]},  32'h3C3C);
    end

    // burst of 6, ack withheld, depth 4
    clr_cap();
    for (int i = 0; i < 6; i++)
      push_byte(25'h20 + 25'(i), 8'h40 + 8'(i));
    repeat (8) tick();
    chk("b_ovf",  {31'd0, overflow}, 32'd1);
    run_ack(40);
    chk("b_nreq", cap_addr.size(), 32'd4);
    if (cap_addr.size() == 4) begin
      chk("b_a0", {10'd0, cap_addr[0]}, 32'h10);
      chk("b_a1", {10'd0, cap_addr[1]}, 32'h10);
      chk("b_a2", {10'd0, cap_addr[2]}, 32'h11);
      chk("b_a3", {10'd0, cap_addr[3]}, 32'h11);
      chk("b_ds1", {30'd0, cap_ds[1]},  32'h2);
      chk("b_ds2", {30'd0, cap_ds[2]},  32'h1);
      chk("b_d0", {16'd0, cap_din[0]},  32'h4040);
      chk("b_d3", {16'd0, cap_din[3]},  32'h4343);
    end

    // full FIFO, push coincides with ack
    do_reset();
    tick();
    clr_cap();
    for (int i = 0; i < 4; i++)
      push_byte(25'h30 + 25'(i), 8'h50 + 8'(i));
    chk("f_req", {31'd0, sd_req}, 32'd1);
    dl_addr = 25'h34;
    dl_data = 8'h54;
    dl_wr   = 1'b1;
    tick();
    dl_wr  = 1'b0;
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("f_ovf0", {31'd0, overflow}, 32'd0);
    run_ack(40);
    chk("f_ovf1", {31'd0, overflow}, 32'd0);
    chk("f_nreq", cap_addr.size(), 32'd5);
    if (cap_addr.size() == 5) begin
      chk("f_a1", {10'd0, cap_addr[1]}, 32'h18);
      chk("f_a4", {10'd0, cap_addr[4]}, 32'h1A);
      chk("f_d4", {16'd0, cap_din[4]},  32'h5454);
      chk("f_s4", {30'd0, cap_ds[4]},   32'h1);
    end

    // download ends with 3 entries pending
    for (int i = 0; i < 3; i++)
      push_byte(25'h40 + 25'(i), 8'h60 + 8'(i));
    dl_download = 1'b0;
    repeat (3) tick();
    chk("e_rl0", {31'd0, rom_loaded}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_req("e_reqto", 10);
      chk("e_rlpre", {31'd0, rom_loaded}, 32'd0);
      ack_now();
    end
    tick();
    chk("e_rl1",   {31'd0, rom_loaded}, 32'd1);
    chk("e_busy",  {31'd0, busy},       32'd0);
    clr_cap();
    push_byte(25'h50, 8'h70);
    repeat (4) tick();
    chk("e_ign",   cap_addr.size(), 32'd0);
    chk("e_ignb",  {31'd0, busy}, 32'd0);
    dl_download = 1'b1;
    tick();
    chk("e_clr",   {31'd0, rom_loaded}, 32'd0);

    // reset during an outstanding request
    push_byte(25'h7FF_FFFF, 8'h99);
    wait_req("r_reqto", 10);
    chk("r_addr", {10'd0, sd_addr}, 32'h3FFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_req",  {31'd0, sd_req}, 32'd0);
    chk("r_busy", {31'd0, busy},   32'd0);
    ack_now();
    repeat (4) tick();
    chk("r_stray", {31'd0, sd_req}, 32'd0);
    chk("r_sbusy", {31'd0, busy},   32'd0);
    chk("r_sbus",  {10'd0, sd_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
